// File: rtl/rwldrv_pkg.sv
// Shared geometry, derived widths and state encoding for the sequenced
// read-wordline driver.
package rwldrv_pkg;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned BANKS = 2;
    localparam int unsigned MAXW  = 24;

    localparam int unsigned BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int unsigned SW = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int unsigned RW = BANKS * ROWS;
    localparam int unsigned XW = ROWS * MAXW;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

endpackage

// File: rtl/rwldrv_plane_mux.sv
// Selects one bit plane across all rows and steers it, inverted, onto the
// chosen bank; every other bank stays idle-high.
module rwldrv_plane_mux
    import rwldrv_pkg::*;
(
    input  logic [XW-1:0] data,
    input  logic [SW-1:0] bit_idx,
    input  logic [BW-1:0] bank,
    output logic [RW-1:0] rwlb_c
);

    logic [MAXW-1:0] row [ROWS];
    logic [ROWS-1:0] plane;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign row[r]   = data[r*MAXW +: MAXW];
        assign plane[r] = row[r][bit_idx];
    end

    // Out-of-range bank values match no slice and leave the bus all ones.
    always_comb begin
        rwlb_c = '1;
        for (int b = 0; b < BANKS; b++) begin
            if (bank == BW'(b)) begin
                rwlb_c[b*ROWS +: ROWS] = ~plane;
            end
        end
    end

endmodule

// File: rtl/rwldrv_seq.sv
// Sequenced read-wordline driver: loads an activation word per row, then walks
// its bit planes MSB-first, one plane per step, with abort and done signalling.
module rwldrv_seq
    import rwldrv_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] xin,
    input  logic [BW-1:0] in_bank,
    input  logic [SW-1:0] in_width,
    input  logic          step,
    input  logic          abort,
    output logic [RW-1:0] rwlb,
    output logic [SW-1:0] bit_idx,
    output logic          busy,
    output logic          last,
    output logic          done
);

    localparam logic [SW-1:0] WMAX = SW'(MAXW - 1);

    state_e        state;
    logic [XW-1:0] data_q;
    logic [BW-1:0] bank_q;

    logic          load_c;
    logic          adv_c;
    logic          fin_c;
    logic          drive_c;
    logic [SW-1:0] wm1_c;
    logic [SW-1:0] idx_c;
    logic [XW-1:0] data_c;
    logic [BW-1:0] bank_c;
    logic [RW-1:0] plane_c;

    // bit_idx doubles as the plane counter: it starts at W-1 and counts down.
    assign wm1_c   = (in_width > WMAX) ? WMAX : in_width;
    assign load_c  = (state == IDLE) && in_valid;
    assign adv_c   = (state == DRIVE) && step && !abort && !last;
    assign fin_c   = (state == DRIVE) && step && !abort && last;
    assign drive_c = load_c || ((state == DRIVE) && !abort && !fin_c);
    assign idx_c   = load_c ? wm1_c : (adv_c ? bit_idx - SW'(1) : bit_idx);
    assign data_c  = load_c ? xin : data_q;
    assign bank_c  = load_c ? in_bank : bank_q;

    rwldrv_plane_mux u_plane_mux (
        .data    (data_c),
        .bit_idx (idx_c),
        .bank    (bank_c),
        .rwlb_c  (plane_c)
    );

    // Outputs are registered from next-state values so a new plane shows one cycle after load/step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            bank_q   <= '0;
            rwlb     <= '1;
            bit_idx  <= '0;
            busy     <= 1'b0;
            last     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            state    <= drive_c ? DRIVE : IDLE;
            data_q   <= data_c;
            bank_q   <= bank_c;
            rwlb     <= drive_c ? plane_c : '1;
            bit_idx  <= drive_c ? idx_c : '0;
            busy     <= drive_c;
            last     <= drive_c && (idx_c == '0);
            done     <= fin_c;
            in_ready <= !drive_c;
        end
    end

endmodule

// File: tb/tb_rwldrv_seq.sv
// Directed and randomized bench for rwldrv_seq against a plane-index model.
module tb_rwldrv_seq;
    import rwldrv_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] xin;
    logic [BW-1:0] in_bank;
    logic [SW-1:0] in_width;
    logic          step;
    logic          abort;
    logic [RW-1:0] rwlb;
    logic [SW-1:0] bit_idx;
    logic          busy;
    logic          last;
    logic          done;

    always #5 clk = ~clk;

    rwldrv_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .xin      (xin),
        .in_bank  (in_bank),
        .in_width (in_width),
        .step     (step),
        .abort    (abort),
        .rwlb     (rwlb),
        .bit_idx  (bit_idx),
        .busy     (busy),
        .last     (last),
        .done     (done)
    );

    int checks = 0;
    int errors = 0;

    // Model: captured rows, bank, plane count W, planes already stepped k.
    logic [MAXW-1:0] m_row [ROWS];
    int              m_bank;
    int              m_w;
    int              m_k;
    bit              m_busy;
    bit              m_done;

    logic [7:0] tbl1 [12] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF,
                              8'h00, 8'h3F, 8'hC0, 8'hC3, 8'hCC, 8'h55};
    logic [7:0] tail2 [5] = '{8'h3F, 8'hC0, 8'hC3, 8'hCC, 8'h55};

    function automatic logic [RW-1:0] exp_plane();
        logic [RW-1:0] e;
        int idx;
        e   = '1;
        idx = m_w - 1 - m_k;
        for (int b = 0; b < BANKS; b++)
            for (int r = 0; r < ROWS; r++)
                if (b == m_bank) e[b*ROWS + r] = ~m_row[r][idx];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_k    = 0;
    endtask

    task automatic set_xin_default();
        for (int r = 0; r < ROWS; r++) xin[r*MAXW +: MAXW] = MAXW'(24'hAAAAAA + r);
    endtask

    task automatic set_xin_random();
        for (int r = 0; r < ROWS; r++) xin[r*MAXW +: MAXW] = MAXW'($urandom);
    endtask

    // One clock with the given controls; update the model from pre-edge state, then compare.
    task automatic cycle(input bit iv, input bit st, input bit ab);
        in_valid = iv;
        step     = st;
        abort    = ab;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (!m_busy) begin
            if (iv) begin
                for (int r = 0; r < ROWS; r++) m_row[r] = xin[r*MAXW +: MAXW];
                m_bank = int'(in_bank);
                m_w    = (int'(in_width) + 1 > MAXW) ? MAXW : int'(in_width) + 1;
                m_k    = 0;
                m_busy = 1'b1;
            end
        end else if (ab) begin
            m_busy = 1'b0;
        end else if (st) begin
            if (m_k == m_w - 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_k++;
            end
        end
        in_valid = 1'b0;
        step     = 1'b0;
        abort    = 1'b0;
        chk("rwlb", rwlb, m_busy ? exp_plane() : {RW{1'b1}});
        chk("busy", busy, m_busy);
        chk("in_ready", in_ready, !m_busy);
        chk("last", last, m_busy && (m_k == m_w - 1));
        chk("done", done, m_done);
        if (m_busy) chk("bit_idx", bit_idx, m_w - 1 - m_k);
    endtask

    initial begin
        int planes;
        rst      = 1'b1;
        in_valid = 1'b0;
        step     = 1'b0;
        abort    = 1'b0;
        in_bank  = '0;
        in_width = '0;
        set_xin_default();
        model_reset();
        #12;
        chk("rst_rwlb", rwlb, 16'hFFFF);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last", last, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: width 12, bank 0
        in_bank  = 1'b0;
        in_width = 5'd11;
        cycle(1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            chk("t1_lo", rwlb[7:0], tbl1[k]);
            chk("t1_hi", rwlb[15:8], 8'hFF);
            chk("t1_last", last, (k == 11));
            cycle(0, 1, 0);
        end
        chk("t1_done", done, 1);
        chk("t1_idle_rwlb", rwlb, 16'hFFFF);
        cycle(0, 0, 0);

        // Test 2: width 24, bank 1
        in_bank  = 1'b1;
        in_width = 5'd23;
        cycle(1, 0, 0);
        for (int k = 0; k < 24; k++) begin
            chk("t2_hi", rwlb[15:8], (k <= 18) ? ((k % 2 == 0) ? 8'h00 : 8'hFF) : tail2[k-19]);
            chk("t2_lo", rwlb[7:0], 8'hFF);
            chk("t2_bit_idx", bit_idx, 23 - k);
            cycle(0, 1, 0);
        end
        chk("t2_done", done, 1);

        // Test 4: load during the done cycle, single plane
        in_bank  = 1'b1;
        in_width = 5'd0;
        cycle(1, 0, 0);
        chk("t4_hi", rwlb[15:8], 8'h55);
        chk("t4_last", last, 1);
        chk("t4_busy", busy, 1);
        cycle(0, 1, 0);
        chk("t4_done", done, 1);

        // Test 3: abort on plane 5 with step also high
        in_bank  = 1'b0;
        in_width = 5'd11;
        cycle(1, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 1, 0);
        chk("t3_bit_idx", bit_idx, 6);
        cycle(0, 1, 1);
        chk("t3_rwlb", rwlb, 16'hFFFF);
        chk("t3_busy", busy, 0);
        chk("t3_in_ready", in_ready, 1);
        chk("t3_done", done, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0);

        // Test 5: hold without step, then load attempt while driving is ignored
        in_bank  = 1'b1;
        in_width = 5'd15;
        cycle(1, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0);
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 0);
            chk("t5_bit_idx_held", bit_idx, 12);
        end
        set_xin_random();
        in_bank  = 1'b0;
        in_width = 5'd3;
        cycle(1, 0, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_bit_idx", bit_idx, 12);
        set_xin_default();
        for (int i = 0; i < 30 && m_busy; i++) cycle(0, 1, 0);
        chk("t5_finished", busy, 0);

        // Test 6: asynchronous reset mid-plane, then clamped width
        in_bank  = 1'b0;
        in_width = 5'd20;
        cycle(1, 0, 0);
        for (int k = 0; k < 4; k++) cycle(0, 1, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_rwlb", rwlb, 16'hFFFF);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_in_ready", in_ready, 1);
        model_reset();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_width = 5'd31;
        cycle(1, 0, 0);
        chk("t6_first_idx", bit_idx, 23);
        planes = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) planes++;
            cycle(0, 1, 0);
            if (done) break;
        end
        chk("t6_planes", planes, 24);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_xin_random();
            in_bank  = BW'($urandom_range(0, BANKS - 1));
            in_width = SW'($urandom_range(0, 31));
            cycle(($urandom % 3) == 0, ($urandom % 2) == 0, ($urandom % 16) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rwldrv_seq.md
Name: rwldrv_seq

Overview:
Sequenced, parametrised read-wordline driver for the DCIM macro. Accepts a full activation word per row through a valid/ready load, then walks the bit planes MSB-first, one plane per controller step. For each plane it drives active-low read wordlines on the selected bank and holds every other bank idle-high. Successor to the combinational 8-row/2-bank/12-or-24-bit driver: it adds arbitrary row, bank and width parameters, runtime width 1..MAXW, internal bit sequencing, abort and completion signalling.

Parameters:
ROWS, 8, wordlines per bank
BANKS, 2, number of banks
MAXW, 24, maximum activation bit width per row
BW, max(1,clog2(BANKS)), bank select width (derived)
SW, clog2(MAXW), bit-index and width-field width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  load request
in_ready  out  1  high only in IDLE
xin  in  ROWS*MAXW  row r occupies xin[r*MAXW +: MAXW]
in_bank  in  BW  target bank
in_width  in  SW  activation bits minus 1; values >= MAXW clamp to MAXW-1
step  in  1  advance to the next plane
abort  in  1  cancel the sequence
rwlb  out  BANKS*ROWS  bank b row r at bit b*ROWS+r, active-low
bit_idx  out  SW  bit currently driven
busy  out  1  high in DRIVE
last  out  1  high while the final plane is driven
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset, asynchronous: state IDLE; rwlb all ones; bit_idx=0; busy=0; last=0; done=0; in_ready=1.
- States: IDLE and DRIVE. All outputs come from registers; no combinational path from input to rwlb.
- Load happens in IDLE when in_valid&in_ready. It captures xin, in_bank and the clamped width W=in_width+1, sets cnt=0 and moves to DRIVE. Plane 0 appears on rwlb in the next cycle (latency 1).
- In DRIVE: bit_idx = W-1-cnt. rwlb[bank*ROWS+r] = ~xin_r[bit_idx]; all other banks are all ones. last = (cnt==W-1).
- Step with last=0: cnt increments and the new plane appears next cycle.
- Step with last=1: next cycle rwlb returns to all ones, done=1 for one cycle, busy=0, state IDLE, in_ready=1.
- A load is accepted in the done cycle, so back-to-back sequences carry no bubble.
- Abort in DRIVE has priority over step. Next cycle: rwlb all ones, IDLE, no done pulse. Abort in IDLE is ignored.
- in_valid during DRIVE is ignored; in_ready=0 and captured data is unchanged.
- in_bank >= BANKS: the sequence still runs and counts steps, rwlb stays all ones, done still pulses.
- in_width=0 (W=1): a single plane, bit 0, with last=1 from the first DRIVE cycle.
- Without step, the current plane is held indefinitely.
- rst mid-sequence forces rwlb all ones immediately, without waiting for a clock edge.

Decomposition:
- Package rwldrv_pkg holds ROWS, BANKS, MAXW, the derived BW/SW and the state enum {IDLE, DRIVE}.
- One combinational sub-module, rwldrv_plane_mux, maps (data, bit_idx, bank) to the next rwlb value. The sequencing FSM and counter live in rwldrv_seq.

Test Plan:
Every test uses xin row r = 24'hAAAAAA+r.
1. Load in_width=11, bank 0, then 12 steps. Plane k rwlb[7:0] = 00,FF,00,FF,00,FF,00,3F,C0,C3,CC,55 with rwlb[15:8]=FF throughout. last is high only on plane 11. done pulses one cycle after the 12th step, and rwlb returns to FFFF in that same cycle.
2. Load in_width=23, bank 1, then 24 steps. rwlb[15:8] is 00/FF alternating for planes 0-18, then 3F,C0,C3,CC,55. rwlb[7:0]=FF throughout. bit_idx runs 23 down to 0.
3. Abort while on plane 5 (width 12, bank 0), with step asserted in the same cycle. Next cycle: rwlb=FFFF, busy=0, done never pulses, in_ready=1.
4. Assert in_valid in the done cycle with in_width=0, bank 1. The load is accepted with no gap. rwlb[15:8]=55 and last=1 on the first DRIVE cycle, and done follows one step later.
5. Hold step low for 10 cycles mid-sequence: plane held constant. Pulse in_valid with new data during DRIVE: in_ready=0 and the output is unaffected.
6. Assert rst asynchronously mid-plane: rwlb=FFFF and busy=0 before the next clock edge. Load with in_width=31 (clamped to 24 bits): 24 planes are produced.
